// File: rtl/imm_gen_pipe.sv
// ARMv8 immediate generator: decodes B/CB/D/I/MOVZ fields from an instruction word and emits
// the extended immediate through a 1- or 2-stage valid/ready pipeline.
module imm_gen_pipe #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned STAGES       = 2,
  parameter int unsigned SHIFT_BRANCH = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal,
  output logic [15:0]     illegal_cnt
);

  typedef enum logic [2:0] {
    FmtNone = 3'd0,
    FmtB    = 3'd1,
    FmtCb   = 3'd2,
    FmtD    = 3'd3,
    FmtI    = 3'd4,
    FmtMov  = 3'd5
  } fmt_e;

  fmt_e        dec_fmt;
  logic        dec_ill;
  logic [25:0] dec_raw;
  logic [1:0]  dec_hw;

  always_comb begin
    dec_fmt = FmtNone;
    dec_raw = '0;
    dec_hw  = '0;
    if (instr[30:26] == 5'b00101) begin
      dec_fmt = FmtB;
      dec_raw = instr[25:0];
    end else if (instr[31:25] == 7'b1011010 || instr[31:24] == 8'b01010100) begin
      dec_fmt = FmtCb;
      dec_raw = {7'd0, instr[23:5]};
    end else if (instr[31:21] == 11'b11111000010 || instr[31:21] == 11'b11111000000) begin
      dec_fmt = FmtD;
      dec_raw = {17'd0, instr[20:12]};
    end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100) begin
      dec_fmt = FmtI;
      dec_raw = {14'd0, instr[21:10]};
    end else if (instr[31:23] == 9'b110100101 && !(XLEN == 32 && instr[22])) begin
      // hw >= 2 would place the field entirely above bit 31 of a 32-bit result
      dec_fmt = FmtMov;
      dec_raw = {10'd0, instr[20:5]};
      dec_hw  = instr[22:21];
    end
    dec_ill = (dec_fmt == FmtNone);
  end

  function automatic logic [XLEN-1:0] extend(fmt_e f, logic [25:0] raw, logic [1:0] hw);
    logic [63:0] full;
    full = '0;
    case (f)
      FmtB: begin
        full = {{38{raw[25]}}, raw};
        if (SHIFT_BRANCH != 0) full = full << 2;
      end
      FmtCb: begin
        full = {{45{raw[18]}}, raw[18:0]};
        if (SHIFT_BRANCH != 0) full = full << 2;
      end
      FmtD:    full = {{55{raw[8]}}, raw[8:0]};
      FmtI:    full = {52'd0, raw[11:0]};
      FmtMov:  full = {48'd0, raw[15:0]} << {hw, 4'b0000};
      default: full = '0;
    endcase
    return full[XLEN-1:0];
  endfunction

  logic            out_valid_q;
  logic [XLEN-1:0] imm_q;
  fmt_e            fmt_q;
  logic            illegal_q;
  logic [15:0]     cnt_q;

  logic            ready_out;
  logic            ready_in;
  logic            st_valid;
  fmt_e            st_fmt;
  logic            st_ill;
  logic [XLEN-1:0] st_imm;

  assign ready_out = !out_valid_q || out_ready;
  assign in_ready  = ready_in && !reset;

  if (STAGES == 2) begin : g_two
    logic        v1_q;
    fmt_e        fmt1_q;
    logic        ill1_q;
    logic [25:0] raw1_q;
    logic [1:0]  hw1_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        v1_q   <= 1'b0;
        fmt1_q <= FmtNone;
        ill1_q <= 1'b0;
        raw1_q <= '0;
        hw1_q  <= '0;
      end else if (ready_in) begin
        v1_q <= in_valid;
        if (in_valid) begin
          fmt1_q <= dec_fmt;
          ill1_q <= dec_ill;
          raw1_q <= dec_raw;
          hw1_q  <= dec_hw;
        end
      end
    end

    assign ready_in = !v1_q || ready_out;
    assign st_valid = v1_q;
    assign st_fmt   = fmt1_q;
    assign st_ill   = ill1_q;
    assign st_imm   = extend(fmt1_q, raw1_q, hw1_q);
  end else begin : g_one
    assign ready_in = ready_out;
    assign st_valid = in_valid;
    assign st_fmt   = dec_fmt;
    assign st_ill   = dec_ill;
    assign st_imm   = extend(dec_fmt, dec_raw, dec_hw);
  end

  // Output register only changes on a load, so a stalled result holds still
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      fmt_q       <= FmtNone;
      illegal_q   <= 1'b0;
    end else if (ready_out) begin
      out_valid_q <= st_valid;
      if (st_valid) begin
        imm_q     <= st_imm;
        fmt_q     <= st_fmt;
        illegal_q <= st_ill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (in_valid && in_ready && dec_ill && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign out_valid   = out_valid_q;
  assign imm         = imm_q;
  assign fmt         = fmt_q;
  assign illegal     = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: vector table on the default build, a 32-bit single-stage
// build, a stalled stream, mid-stream reset and illegal counter saturation.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid, illegal;
  logic [63:0] imm;
  logic [2:0]  fmt;
  logic [15:0] illegal_cnt;

  logic        in_valid32;
  logic [31:0] instr32;
  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [15:0] illegal_cnt32;

  always #5 clk = ~clk;

  imm_gen_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .imm        (imm),
    .fmt        (fmt),
    .illegal    (illegal),
    .illegal_cnt(illegal_cnt)
  );

  imm_gen_pipe #(
    .XLEN        (32),
    .STAGES      (1),
    .SHIFT_BRANCH(1)
  ) dut32 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid32),
    .in_ready   (in_ready32),
    .instr      (instr32),
    .out_valid  (out_valid32),
    .out_ready  (out_ready),
    .imm        (imm32),
    .fmt        (fmt32),
    .illegal    (illegal32),
    .illegal_cnt(illegal_cnt32)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t vecs[12];
  vec_t vecs32[4];
  int   passes = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run64(input int idx);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = vecs[idx].instr;
    #1 check($sformatf("in_ready[%0d]", idx), in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency[%0d]", idx), lat, 2);
    check($sformatf("imm[%0d]", idx), imm, vecs[idx].imm);
    check($sformatf("fmt[%0d]", idx), fmt, vecs[idx].fmt);
    check($sformatf("illegal[%0d]", idx), illegal, vecs[idx].ill);
  endtask

  task automatic run32(input int idx);
    int lat;
    @(negedge clk);
    out_ready  = 1'b1;
    in_valid32 = 1'b1;
    instr32    = vecs32[idx].instr;
    @(negedge clk);
    in_valid32 = 1'b0;
    lat = 1;
    while (!out_valid32 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("x32_latency[%0d]", idx), lat, 1);
    check($sformatf("x32_imm[%0d]", idx), imm32, vecs32[idx].imm);
    check($sformatf("x32_fmt[%0d]", idx), fmt32, vecs32[idx].fmt);
    check($sformatf("x32_illegal[%0d]", idx), illegal32, vecs32[idx].ill);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t q[$];
    vec_t e;
    int   sent, got, n, stale;
    logic stalled_prev, exp_rdy, in_fire, out_fire;
    logic [63:0] prev_imm;
    logic [2:0]  prev_fmt;

    vecs[0]  = '{32'h17FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0}; // B, imm26 = -1
    vecs[1]  = '{32'h1400_0001, 64'h0000_0000_0000_0004, 3'd1, 1'b0}; // B, +1
    vecs[2]  = '{32'hB480_0000, 64'hFFFF_FFFF_FFF0_0000, 3'd2, 1'b0}; // CBZ, imm19 = 40000
    vecs[3]  = '{32'h5400_0020, 64'h0000_0000_0000_0004, 3'd2, 1'b0}; // B.cond, +1
    vecs[4]  = '{32'hF85F_F000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 1'b0}; // LDUR, imm9 = 1FF
    vecs[5]  = '{32'hF801_0000, 64'h0000_0000_0000_0010, 3'd3, 1'b0}; // STUR, imm9 = 010
    vecs[6]  = '{32'h913F_FC00, 64'h0000_0000_0000_0FFF, 3'd4, 1'b0}; // ADDI, imm12 = FFF
    vecs[7]  = '{32'hD120_0000, 64'h0000_0000_0000_0800, 3'd4, 1'b0}; // SUBI, imm12 = 800
    vecs[8]  = '{32'hD2F7_DDE0, 64'hBEEF_0000_0000_0000, 3'd5, 1'b0}; // MOVZ BEEF, hw 3
    vecs[9]  = '{32'hD2A2_4680, 64'h0000_0000_1234_0000, 3'd5, 1'b0}; // MOVZ 1234, hw 1
    vecs[10] = '{32'h0000_0000, 64'h0,                   3'd0, 1'b1};
    vecs[11] = '{32'hFFFF_FFFF, 64'h0,                   3'd0, 1'b1};

    vecs32[0] = '{32'h17FF_FFFF, 64'h0000_0000_FFFF_FFFC, 3'd1, 1'b0};
    vecs32[1] = '{32'hD2F7_DDE0, 64'h0,                   3'd0, 1'b1};
    vecs32[2] = '{32'hD2A2_4680, 64'h0000_0000_1234_0000, 3'd5, 1'b0};
    vecs32[3] = '{32'hF85F_F000, 64'h0000_0000_FFFF_FFFF, 3'd3, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    in_valid32 = 1'b0; instr32 = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_imm", imm, 0);
    check("rst_fmt", fmt, 0);
    check("rst_illegal", illegal, 0);
    check("rst_cnt", illegal_cnt, 0);
    reset = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 12; i++) run64(i);
    for (int i = 0; i < 4; i++) run32(i);
    check("x32_cnt", illegal_cnt32, 1);

    // Stream with out_ready toggling 1,0,0,1,...
    sent = 0; got = 0; n = 0; stalled_prev = 1'b0; prev_imm = '0; prev_fmt = '0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 8);
      instr     = vecs[(sent < 8) ? sent : 0].instr;
      #1;
      if (stalled_prev && out_valid) begin
        check("stall_imm_stable", imm, prev_imm);
        check("stall_fmt_stable", fmt, prev_fmt);
      end
      exp_rdy = !(n == 2 && !out_ready);
      check($sformatf("stream_in_ready[%0d]", cyc), in_ready, exp_rdy);
      out_fire = out_valid && out_ready;
      in_fire  = in_valid && in_ready;
      if (out_fire) begin
        check("stream_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check($sformatf("stream_imm[%0d]", got), imm, e.imm);
          check($sformatf("stream_fmt[%0d]", got), fmt, e.fmt);
        end
        got++;
      end
      if (in_fire) begin
        q.push_back(vecs[sent]);
        sent++;
      end
      n = n + int'(in_fire) - int'(out_fire);
      stalled_prev = out_valid && !out_ready;
      prev_imm = imm;
      prev_fmt = fmt;
    end
    in_valid = 1'b0;
    check("stream_count", got, 8);

    // Two illegal words in flight, then a one-cycle reset
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("cnt_before_flush", illegal_cnt, 2);
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h0;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #1 check("cnt_in_flight", illegal_cnt, 4);
    check("flush_out_valid_pre", out_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_cnt", illegal_cnt, 0);
    check("mid_rst_imm", imm, 0);
    check("mid_rst_illegal", illegal, 0);
    reset = 1'b0; out_ready = 1'b1;
    #1 check("mid_post_rst_in_ready", in_ready, 1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_output", stale, 0);

    // Saturation of the illegal counter
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'hFFFF_FFFF;
    repeat (65534) @(negedge clk);
    in_valid = 1'b0;
    #1 check("cnt_fffe", illegal_cnt, 16'hFFFE);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    #1 check("cnt_sat", illegal_cnt, 16'hFFFF);
    repeat (3) @(negedge clk);
    check("cnt_sat_hold", illegal_cnt, 16'hFFFF);
    check("drained", out_valid, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameters SHALL be: XLEN, 64, output immediate width (32 or 64 only); STAGES, 2, pipeline depth (1 or 2 only); SHIFT_BRANCH, 1, when 1 branch offsets are shifted left by 2.
REQ-002 Ports SHALL be, in order:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction word present.
- in_ready  out  1  block accepts the word this cycle.
- instr  in  32  ARMv8 instruction word.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- imm  out  XLEN  extended immediate.
- fmt  out  3  format code: 0 NONE, 1 B, 2 CB, 3 D, 4 I, 5 MOV.
- illegal  out  1  no supported format matched.
- illegal_cnt  out  16  saturating count of accepted illegal words.

Function
REQ-003 A transfer SHALL occur on any cycle where valid and ready are both high; the input side and the output side are independent.
REQ-004 Decode SHALL use these instr fields:
- [31:26]=000101 or 100101: B. imm26=[25:0], sign-extended.
- [31:25]=1011010 (CBZ/CBNZ) or [31:24]=01010100 (B.cond): CB. imm19=[23:5], sign-extended.
- [31:21]=11111000010 or 11111000000: D. imm9=[20:12], sign-extended.
- [31:22]=1001000100 or 1101000100: I. imm12=[21:10], zero-extended.
- [31:23]=110100101 (MOVZ): MOV. imm16=[20:5], zero-extended, shifted left by 16*[22:21].
REQ-005 When SHIFT_BRANCH=1, B and CB results SHALL be the sign-extended value shifted left by 2; D, I and MOV SHALL never be shifted.
REQ-006 When no pattern matches, the block SHALL produce fmt=0, imm=0 and illegal=1.
REQ-007 When XLEN=32 and the word is MOVZ with [22] set, the block SHALL produce fmt=0, imm=0 and illegal=1.
REQ-008 Sign extension SHALL replicate the top field bit, after any shift, through bit XLEN-1; there SHALL be no truncation of any supported field at XLEN=32.
REQ-009 When STAGES=2, stage 1 SHALL register fmt, illegal and the raw field (with the MOV shift amount), and stage 2 SHALL register the extended imm.
REQ-010 When STAGES=1, decode and extension SHALL both complete before a single output register.
REQ-011 Latency from an input transfer to out_valid SHALL be exactly STAGES cycles when out_ready is held high.
REQ-012 Each stage SHALL load when it is empty or the stage downstream of it is transferring: ready_k = !valid_k || ready_(k+1), and in_ready = ready_1.
REQ-013 With out_ready held high, throughput SHALL be one word per cycle with no bubbles.
REQ-014 While out_valid=1 and out_ready=0, imm, fmt and illegal SHALL stay stable.
REQ-015 No accepted word SHALL be dropped or duplicated.
REQ-016 Words SHALL leave in acceptance order.
REQ-017 illegal_cnt SHALL increment by 1 on each input transfer whose word is illegal.
REQ-018 illegal_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-019 A simultaneous input transfer and output transfer on one cycle SHALL both complete.

Reset
REQ-020 While reset=1 at a clock edge, all stage valids SHALL clear, out_valid=0, imm=0, fmt=0, illegal=0 and illegal_cnt=0.
REQ-021 While reset=1, in_ready SHALL be 0.
REQ-022 In the first cycle after reset deasserts, in_ready SHALL be 1.
REQ-023 Reset asserted mid-stream SHALL discard every in-flight word; no discarded word SHALL appear at the output afterwards.

Verification
REQ-024 B with instr=32'h17FFFFFF (imm26=-1), XLEN=64, SHIFT_BRANCH=1 -> imm=64'hFFFF_FFFF_FFFF_FFFC, fmt=1, out_valid exactly 2 cycles after acceptance.
REQ-025 CBZ with imm19=19'h40000 -> imm=64'hFFFF_FFFF_FFF0_0000, fmt=2.
REQ-025 (cont.) LDUR with imm9=9'h1FF -> imm=all ones, fmt=3.
REQ-025 (cont.) ADDI with imm12=12'hFFF -> imm=64'h0000_0000_0000_0FFF, fmt=4.
REQ-026 MOVZ with imm16=16'hBEEF and hw=3 -> imm=64'hBEEF_0000_0000_0000, fmt=5.
REQ-026 (cont.) The same MOVZ at XLEN=32 -> illegal=1, imm=0.
REQ-027 Stream 8 mixed words while out_ready toggles 1,0,0,1,... -> every result is produced in order; imm is stable while stalled; in_ready drops only when both stages are full.
REQ-028 Preload illegal_cnt to 16'hFFFE, then feed 3 illegal words -> illegal_cnt reads 16'hFFFF and holds.
REQ-029 Feed 2 words, then assert reset for 1 cycle -> out_valid=0 and illegal_cnt=0; no stale result appears afterwards.
